bus_region_decoder: RTL and testbench
=====================================

# bus_region_decoder

Parametrised 6809 bus-cycle engine that replaces fixed per-peripheral chip-enable and data-bus tri-state logic with one registered block. It sits between the level-translated 6809 bus and the peripherals (SRAM, SPI flash controller, UART, expansion areas):
- decodes up to NUM_REGIONS address windows;
- stretches E through MRDY, using per-region wait states plus a peripheral ready handshake;
- registers read data;
- emits a single data-bus output enable.

Unmapped accesses and hung peripherals are detected and counted.

## Interface
Parameters:
- NUM_REGIONS, 4, number of decoded windows (1-8)
- ADDR_W, 16, CPU address width
- DATA_W, 8, data width
- WAIT_W, 4, width of each per-region wait-state count
- REGION_BASE, {16'hF000,16'hA000,16'h1000,16'h0000}, flattened NUM_REGIONS*ADDR_W bases; region k at bits [k*ADDR_W +: ADDR_W]
- REGION_MASK, {16'hF000,16'hE000,16'h8000,16'hF000}, flattened compare masks; hit when (addr & mask) == (base & mask)
- REGION_WAIT, {4'd3,4'd0,4'd0,4'd0}, flattened minimum wait cycles per region
- TIMEOUT, 255, max clk cycles MRDY may be held low (used only with BUS_TIMEOUT_EN)

Ports:
- clk  in  1  internal oscillator clock; one clock for the whole block
- reset  in  1  asynchronous, active-high
- i_E  in  1  6809 E, asynchronous to clk
- i_RW  in  1  6809 R/W (1 = read)
- i_ADDRESS_BUS  in  ADDR_W  CPU address
- i_region_rdata  in  NUM_REGIONS*DATA_W  flattened read data from each peripheral
- i_region_ready  in  NUM_REGIONS  peripheral data valid / write accepted
- o_region_ce  out  NUM_REGIONS  one-hot region select, registered
- o_rd_data  out  DATA_W  registered read data for DATA_BUS
- o_data_oe  out  1  drive DATA_BUS with o_rd_data
- o_MRDY  out  1  0 = stretch E
- o_bus_err  out  1  sticky unmapped/timeout flag
- o_err_count  out  8  saturating error counter

## Operation
- i_E, i_RW and i_ADDRESS_BUS are captured through a 2-flop synchroniser. A rising edge of synced E starts a cycle, and the address and RW are latched at that edge.
- Decode is priority-based: the lowest-index matching region wins. Overlapping windows are legal.
- State machine:
  - IDLE: on E rise with a hit, go to WAIT; load the wait counter with REGION_WAIT[k]; o_region_ce[k]=1; o_MRDY=0. On E rise with no hit, go to DONE; set o_bus_err; increment o_err_count; o_rd_data=all-ones.
  - WAIT: decrement the counter each cycle. When the counter is 0 and i_region_ready[k]=1, capture i_region_rdata[k] into o_rd_data (reads only) and go to DONE.
  - DONE: o_MRDY=1. o_data_oe = latched RW & E_sync. On synced E fall, clear o_region_ce and o_data_oe, then go to IDLE.
- o_MRDY is 1 in every state except WAIT.
- A write cycle never asserts o_data_oe. Ready still gates MRDY, so a slow write stretches E the same way a slow read does.
- Wait states and ready are ANDed: the cycle completes only when both conditions hold.
- o_err_count saturates at 8'hFF. o_bus_err clears only on reset.

## Timing
- Reset values: o_region_ce=0, o_rd_data=0, o_data_oe=0, o_MRDY=1, o_bus_err=0, o_err_count=0; state=IDLE.
- E rise to o_region_ce/o_MRDY=0: 3 clk (2 sync + 1 register).
- With REGION_WAIT=W and ready already high:
  - MRDY low for W+1 clk;
  - o_rd_data valid on the cycle MRDY returns to 1;
  - o_data_oe asserted in that same cycle.
- A zero-wait region with ready high still stretches MRDY for 1 clk.
- E fall to o_data_oe=0: 3 clk.
- An E rise arriving in DONE before the fall is seen (cannot occur on a legal bus) is ignored. A new cycle starts only from IDLE.
- reset asserted mid-cycle: all outputs return to reset values asynchronously. After reset is released, the block waits for the next synced E rise.
- An address change during WAIT is ignored; the latched address and region are used.

## Configuration
- BUS_TIMEOUT_EN defined:
  - a cycle counter runs in WAIT;
  - on reaching TIMEOUT, force DONE with o_rd_data=all-ones, set o_bus_err and increment o_err_count;
  - MRDY is released on that cycle.
- BUS_TIMEOUT_EN undefined: WAIT persists until ready, with no counter logic; MRDY can be held low indefinitely.

## Test plan
- Read 0x0123 (region 0, wait 0, ready=1, rdata=8'h5A):
  - o_region_ce=4'b0001;
  - MRDY low for exactly 1 clk;
  - o_rd_data=8'h5A with o_data_oe=1 until 3 clk after E falls.
- Read 0xF010 (region 3, wait 3); ready goes high 6 clk after CE:
  - MRDY low for 7 clk;
  - data is captured on the ready cycle.
- Write 0xA001 (region 2):
  - o_region_ce=4'b0100;
  - o_data_oe stays 0 throughout;
  - MRDY is released when ready is seen.
- Read unmapped 0x9000:
  - no CE asserted;
  - o_rd_data=8'hFF;
  - o_bus_err=1;
  - o_err_count increments by 1 and saturates at 255 after 300 such reads.
- With BUS_TIMEOUT_EN and TIMEOUT=255, region 3 ready held 0:
  - MRDY returns to 1 after 255 clk in WAIT;
  - data=8'hFF and the error is counted.
- Assert reset during WAIT:
  - o_MRDY=1 and o_region_ce=0 immediately;
  - the next E cycle after release decodes normally.

Source files
------------

// File: rtl/bus_region_decoder.sv
// bus_region_decoder: registered 6809 bus-cycle engine. Decodes up to
// NUM_REGIONS address windows, stretches E via MRDY using per-region wait
// states ANDed with a peripheral ready, registers read data and drives a
// single data-bus output enable. Unmapped cycles are flagged and counted.
// Optional feature macro: BUS_TIMEOUT_EN adds a WAIT-state watchdog that
// forces completion after TIMEOUT clk cycles.
module bus_region_decoder #(
  parameter int unsigned NUM_REGIONS = 4,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned WAIT_W      = 4,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = {16'hF000, 16'hA000, 16'h1000, 16'h0000},
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK = {16'hF000, 16'hE000, 16'h8000, 16'hF000},
  parameter logic [NUM_REGIONS*WAIT_W-1:0] REGION_WAIT = {4'd3, 4'd0, 4'd0, 4'd0},
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_E,
  input  logic                          i_RW,
  input  logic [ADDR_W-1:0]             i_ADDRESS_BUS,
  input  logic [NUM_REGIONS*DATA_W-1:0] i_region_rdata,
  input  logic [NUM_REGIONS-1:0]        i_region_ready,
  output logic [NUM_REGIONS-1:0]        o_region_ce,
  output logic [DATA_W-1:0]             o_rd_data,
  output logic                          o_data_oe,
  output logic                          o_MRDY,
  output logic                          o_bus_err,
  output logic [7:0]                    o_err_count
);

  localparam int unsigned IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  // Synchroniser stages
  logic              e_meta_q, e_sync_q, e_prev_q;
  logic              rw_meta_q, rw_sync_q;
  logic [ADDR_W-1:0] addr_meta_q, addr_sync_q;

  // Cycle state
  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       region_q, region_d;
  logic                   rw_q, rw_d;
  logic [WAIT_W-1:0]      wcnt_q, wcnt_d;
  logic [NUM_REGIONS-1:0] ce_q, ce_d;
  logic [DATA_W-1:0]      rd_data_q, rd_data_d;
  logic                   data_oe_q, data_oe_d;
  logic                   mrdy_q, mrdy_d;
  logic                   bus_err_q, bus_err_d;
  logic [7:0]             err_cnt_q, err_cnt_d;

  // Combinational helpers
  logic                   e_rise_c;
  logic                   hit_c;
  logic [IDX_W-1:0]       hit_idx_c;
  logic [WAIT_W-1:0]      hit_wait_c;
  logic [NUM_REGIONS-1:0] hit_ce_c;
  logic [DATA_W-1:0]      sel_rdata_c;
  logic                   sel_ready_c;
  logic [7:0]             err_cnt_inc_c;

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [TMO_W-1:0] tmo_q, tmo_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
`endif

  // Two-flop synchronisers; E stages reset high so a cycle needs a real low-to-high E after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_meta_q    <= 1'b1;
      e_sync_q    <= 1'b1;
      e_prev_q    <= 1'b1;
      rw_meta_q   <= 1'b0;
      rw_sync_q   <= 1'b0;
      addr_meta_q <= '0;
      addr_sync_q <= '0;
    end else begin
      e_meta_q    <= i_E;
      e_sync_q    <= e_meta_q;
      e_prev_q    <= e_sync_q;
      rw_meta_q   <= i_RW;
      rw_sync_q   <= rw_meta_q;
      addr_meta_q <= i_ADDRESS_BUS;
      addr_sync_q <= addr_meta_q;
    end
  end

  assign e_rise_c      = e_sync_q & ~e_prev_q;
  assign err_cnt_inc_c = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
  assign hit_ce_c      = NUM_REGIONS'(1) << hit_idx_c;

  // Priority decode of the synced address: scanning downward lets the lowest index win
  always_comb begin
    hit_c      = 1'b0;
    hit_idx_c  = '0;
    hit_wait_c = '0;
    for (int k = int'(NUM_REGIONS) - 1; k >= 0; k--) begin
      if ((addr_sync_q & REGION_MASK[k*ADDR_W +: ADDR_W]) ==
          (REGION_BASE[k*ADDR_W +: ADDR_W] & REGION_MASK[k*ADDR_W +: ADDR_W])) begin
        hit_c      = 1'b1;
        hit_idx_c  = IDX_W'(k);
        hit_wait_c = REGION_WAIT[k*WAIT_W +: WAIT_W];
      end
    end
  end

  // Read-data and ready mux for the latched region
  always_comb begin
    sel_rdata_c = '0;
    sel_ready_c = 1'b0;
    for (int k = 0; k < int'(NUM_REGIONS); k++) begin
      if (region_q == IDX_W'(k)) begin
        sel_rdata_c = i_region_rdata[k*DATA_W +: DATA_W];
        sel_ready_c = i_region_ready[k];
      end
    end
  end

  // Next-state and registered-output logic for the bus cycle
  always_comb begin
    state_d   = state_q;
    region_d  = region_q;
    rw_d      = rw_q;
    wcnt_d    = wcnt_q;
    ce_d      = ce_q;
    rd_data_d = rd_data_q;
    bus_err_d = bus_err_q;
    err_cnt_d = err_cnt_q;
`ifdef BUS_TIMEOUT_EN
    tmo_d     = '0;
`endif
    case (state_q)
      S_IDLE: begin
        ce_d = '0;
        if (e_rise_c) begin
          rw_d = rw_sync_q;
          if (hit_c) begin
            state_d  = S_WAIT;
            region_d = hit_idx_c;
            wcnt_d   = hit_wait_c;
            ce_d     = hit_ce_c;
          end else begin
            state_d   = S_DONE;
            rd_data_d = '1;
            bus_err_d = 1'b1;
            err_cnt_d = err_cnt_inc_c;
          end
        end
      end
      S_WAIT: begin
        if (wcnt_q == '0 && sel_ready_c) begin
          state_d = S_DONE;
          if (rw_q) begin
            rd_data_d = sel_rdata_c;
          end
        end
`ifdef BUS_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          state_d   = S_DONE;
          rd_data_d = '1;
          bus_err_d = 1'b1;
          err_cnt_d = err_cnt_inc_c;
        end
`endif
        else begin
          if (wcnt_q != '0) begin
            wcnt_d = wcnt_q - WAIT_W'(1);
          end
`ifdef BUS_TIMEOUT_EN
          tmo_d = tmo_q + TMO_W'(1);
`endif
        end
      end
      S_DONE: begin
        if (!e_sync_q) begin
          state_d = S_IDLE;
          ce_d    = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    mrdy_d    = (state_d != S_WAIT);
    data_oe_d = (state_d == S_DONE) && rw_d && e_sync_q;
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      region_q  <= '0;
      rw_q      <= 1'b0;
      wcnt_q    <= '0;
      ce_q      <= '0;
      rd_data_q <= '0;
      data_oe_q <= 1'b0;
      mrdy_q    <= 1'b1;
      bus_err_q <= 1'b0;
      err_cnt_q <= '0;
`ifdef BUS_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      region_q  <= region_d;
      rw_q      <= rw_d;
      wcnt_q    <= wcnt_d;
      ce_q      <= ce_d;
      rd_data_q <= rd_data_d;
      data_oe_q <= data_oe_d;
      mrdy_q    <= mrdy_d;
      bus_err_q <= bus_err_d;
      err_cnt_q <= err_cnt_d;
`ifdef BUS_TIMEOUT_EN
      tmo_q     <= tmo_d;
`endif
    end
  end

  assign o_region_ce = ce_q;
  assign o_rd_data   = rd_data_q;
  assign o_data_oe   = data_oe_q;
  assign o_MRDY      = mrdy_q;
  assign o_bus_err   = bus_err_q;
  assign o_err_count = err_cnt_q;

endmodule

// File: tb/tb_bus_region_decoder.sv
// Testbench for bus_region_decoder: table of bus cycles with a scoreboard
// queue, plus hand-written saturation, reset-during-WAIT and (with
// BUS_TIMEOUT_EN) watchdog sequences.
module tb_bus_region_decoder;

  localparam int unsigned NR = 4;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_E;
  logic          i_RW;
  logic [AW-1:0] i_ADDRESS_BUS;
  logic [NR*DW-1:0] i_region_rdata;
  logic [NR-1:0] i_region_ready;
  logic [NR-1:0] o_region_ce;
  logic [DW-1:0] o_rd_data;
  logic          o_data_oe;
  logic          o_MRDY;
  logic          o_bus_err;
  logic [7:0]    o_err_count;

  bus_region_decoder dut (
    .clk            (clk),
    .reset          (reset),
    .i_E            (i_E),
    .i_RW           (i_RW),
    .i_ADDRESS_BUS  (i_ADDRESS_BUS),
    .i_region_rdata (i_region_rdata),
    .i_region_ready (i_region_ready),
    .o_region_ce    (o_region_ce),
    .o_rd_data      (o_rd_data),
    .o_data_oe      (o_data_oe),
    .o_MRDY         (o_MRDY),
    .o_bus_err      (o_bus_err),
    .o_err_count    (o_err_count)
  );

  always #5 clk = ~clk;

  // rdy_dly: 0 = target ready high from the start, n>0 = raised n clk after CE, -1 = never
  typedef struct {
    logic [15:0] addr;
    logic        rw;
    int          rdy_dly;
    logic [7:0]  rdata;
    logic [3:0]  exp_ce;
    int          exp_lo;
    logic [7:0]  exp_rd;
    logic        exp_oe;
    logic        err_cyc;
  } vec_t;

  vec_t       vecs[10];
  vec_t       exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic       model_err;
  logic [7:0] model_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Run one complete E cycle and score it against the queued expectation
  task automatic run_vec(input vec_t v);
    vec_t       e;
    int         ce_at, lo, tgt;
    logic [3:0] ce_seen;
    logic [7:0] rd;
    logic       oe, oe_any, done;
    ce_at = 0; lo = 0; tgt = -1; ce_seen = '0; rd = '0; oe = 1'b0; oe_any = 1'b0; done = 1'b0;
    for (int k = 0; k < int'(NR); k++) begin
      if (v.exp_ce[k]) tgt = k;
      i_region_rdata[k*DW +: DW] = 8'hE0 | 8'(k);
    end
    i_region_ready = '1;
    if (tgt >= 0) begin
      i_region_rdata[tgt*DW +: DW] = v.rdata;
      if (v.rdy_dly != 0) i_region_ready[tgt] = 1'b0;
    end
    @(negedge clk);
    i_ADDRESS_BUS = v.addr;
    i_RW          = v.rw;
    i_E           = 1'b1;
    exp_q.push_back(v);
    if (v.err_cyc) begin
      model_err = 1'b1;
      if (model_cnt != 8'hFF) model_cnt = model_cnt + 8'd1;
    end
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (o_data_oe) oe_any = 1'b1;
      if (ce_at == 0 && o_region_ce != '0) begin
        ce_at   = n;
        ce_seen = o_region_ce;
      end
      if (ce_at > 0 && n == ce_at + 1) i_ADDRESS_BUS = ~v.addr;
      if (tgt >= 0 && v.rdy_dly > 0 && ce_at > 0 && n == ce_at + v.rdy_dly) i_region_ready[tgt] = 1'b1;
      if (!o_MRDY) lo++;
      else if (n >= 3 && (lo > 0 || v.exp_ce == '0)) begin
        rd   = o_rd_data;
        oe   = o_data_oe;
        done = 1'b1;
        break;
      end
    end
    e = exp_q.pop_front();
    chk("cycle_done", 32'(done), 32'd1);
    chk("region_ce", 32'(ce_seen), 32'(e.exp_ce));
    chk("ce_latency", 32'(ce_at), (e.exp_ce != '0) ? 32'd3 : 32'd0);
    chk("mrdy_low_clks", 32'(lo), 32'(e.exp_lo));
    chk("rd_data", 32'(rd), 32'(e.exp_rd));
    chk("data_oe", 32'(oe), 32'(e.exp_oe));
    chk("bus_err", 32'(o_bus_err), 32'(model_err));
    chk("err_count", 32'(o_err_count), 32'(model_cnt));
    i_E = 1'b0;
    @(negedge clk);
    if (o_data_oe) oe_any = 1'b1;
    @(negedge clk);
    if (o_data_oe) oe_any = 1'b1;
    chk("oe_hold_after_fall", 32'(o_data_oe), 32'(e.exp_oe));
    @(negedge clk);
    chk("oe_drop_3clk", 32'(o_data_oe), 32'd0);
    chk("ce_drop_3clk", 32'(o_region_ce), 32'd0);
    if (!v.rw) chk("write_never_oe", 32'(oe_any), 32'd0);
    i_region_ready = '0;
    repeat (2) @(negedge clk);
  endtask

  // Short unmapped read used for the saturation sweep
  task automatic unmapped_read();
    @(negedge clk);
    i_ADDRESS_BUS = 16'h9000;
    i_RW          = 1'b1;
    i_E           = 1'b1;
    if (model_cnt != 8'hFF) model_cnt = model_cnt + 8'd1;
    model_err = 1'b1;
    repeat (5) @(negedge clk);
    i_E = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'h0123, 1'b1,  0, 8'h5A, 4'b0001, 1, 8'h5A, 1'b1, 1'b0};
    vecs[1] = '{16'hF010, 1'b1,  6, 8'hC3, 4'b1000, 7, 8'hC3, 1'b1, 1'b0};
    vecs[2] = '{16'hA001, 1'b0,  2, 8'h99, 4'b0100, 3, 8'hC3, 1'b0, 1'b0};
    vecs[3] = '{16'h9000, 1'b1,  0, 8'h00, 4'b0000, 0, 8'hFF, 1'b1, 1'b1};
    vecs[4] = '{16'h1234, 1'b1,  0, 8'h77, 4'b0010, 1, 8'h77, 1'b1, 1'b0};
    vecs[5] = '{16'hF0FF, 1'b1,  0, 8'h3C, 4'b1000, 4, 8'h3C, 1'b1, 1'b0};
    vecs[6] = '{16'h7FFF, 1'b0,  0, 8'h11, 4'b0010, 1, 8'h3C, 1'b0, 1'b0};
    vecs[7] = '{16'hC000, 1'b0,  0, 8'h00, 4'b0000, 0, 8'hFF, 1'b0, 1'b1};
    vecs[8] = '{16'hAFFF, 1'b1,  0, 8'hA5, 4'b0100, 1, 8'hA5, 1'b1, 1'b0};
    vecs[9] = '{16'hF010, 1'b1,  1, 8'h6B, 4'b1000, 4, 8'h6B, 1'b1, 1'b0};

    reset = 1'b1; i_E = 1'b0; i_RW = 1'b1; i_ADDRESS_BUS = '0;
    i_region_rdata = '0; i_region_ready = '0;
    model_err = 1'b0; model_cnt = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_ce", 32'(o_region_ce), 32'd0);
    chk("rst_rd_data", 32'(o_rd_data), 32'd0);
    chk("rst_oe", 32'(o_data_oe), 32'd0);
    chk("rst_mrdy", 32'(o_MRDY), 32'd1);
    chk("rst_bus_err", 32'(o_bus_err), 32'd0);
    chk("rst_err_count", 32'(o_err_count), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_after_release_ce", 32'(o_region_ce), 32'd0);

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

`ifdef BUS_TIMEOUT_EN
    begin
      vec_t t;
      t = '{16'hF010, 1'b1, -1, 8'h00, 4'b1000, 255, 8'hFF, 1'b1, 1'b1};
      run_vec(t);
    end
`endif

    for (int i = 0; i < 300; i++) unmapped_read();
    chk("sat_err_count", 32'(o_err_count), 32'(model_cnt));
    chk("sat_err_count_ff", 32'(o_err_count), 32'hFF);
    chk("sat_bus_err", 32'(o_bus_err), 32'd1);
    chk("sat_rd_data", 32'(o_rd_data), 32'hFF);

    // Reset asserted mid-WAIT on a slow region
    @(negedge clk);
    i_region_ready = '0;
    i_ADDRESS_BUS  = 16'hF010;
    i_RW           = 1'b1;
    i_E            = 1'b1;
    repeat (5) @(negedge clk);
    chk("pre_rst_mrdy_low", 32'(o_MRDY), 32'd0);
    chk("pre_rst_ce", 32'(o_region_ce), 32'h8);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_mrdy", 32'(o_MRDY), 32'd1);
    chk("async_rst_ce", 32'(o_region_ce), 32'd0);
    chk("async_rst_oe", 32'(o_data_oe), 32'd0);
    chk("async_rst_err", 32'(o_bus_err), 32'd0);
    chk("async_rst_cnt", 32'(o_err_count), 32'd0);
    chk("async_rst_rd", 32'(o_rd_data), 32'd0);
    model_err = 1'b0;
    model_cnt = 8'd0;
    @(negedge clk);
    i_E = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_idle_mrdy", 32'(o_MRDY), 32'd1);
    run_vec(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
